// File: rtl/bcd_to_binary_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_binary_seq_pkg
//  Description : Shared constants, FSM state type and helper function for
//                the sequential BCD-to-binary converter.
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_to_binary_seq_pkg;

  localparam int          BCD_DIGIT_W     = 4;
  localparam logic [3:0]  BCD_CORR_THRESH = 4'd8;
  localparam logic [3:0]  BCD_CORR_VAL    = 4'd3;
  localparam logic [3:0]  BCD_MAX_DIGIT   = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Ceiling log2, usable in constant expressions (clog2(1) = 0).
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < value) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_binary_seq_resta3.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_resta3
//  Description : Combinational BCD digit corrector for reverse double-dabble:
//                a digit at or above 8 after a right shift is reduced by 3.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_resta3
  import bcd_to_binary_seq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  // Digit >= 8 never underflows when 3 is subtracted.
  assign digit_o = (digit_i >= BCD_CORR_THRESH) ? (digit_i - BCD_CORR_VAL) : digit_i;

endmodule
`default_nettype wire

// File: rtl/bcd_to_binary_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_binary_seq
//  Description : Sequential BCD-to-binary converter (reverse double-dabble).
//                One right shift plus per-digit correction per clock, BIN_W
//                shifts per conversion, valid/ready input and one-cycle
//                out_valid pulse. Invalid digits force a zero result with
//                bcd_err set, after the full latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_binary_seq
  import bcd_to_binary_seq_pkg::*;
#(
  parameter int N_DIGITS = 2,
  parameter int BIN_W    = 7
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [BCD_DIGIT_W*N_DIGITS-1:0] bcd_in,
  output logic                         out_valid,
  output logic [BIN_W-1:0]             bin_out,
  output logic                         bcd_err
);

  localparam int BCD_W = BCD_DIGIT_W * N_DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  // At least one bit so BIN_W = 1 still has a legal counter.
  localparam int CNT_W = (clog2(BIN_W) < 1) ? 1 : clog2(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  if (BIN_W < clog2(10 ** N_DIGITS)) begin : g_bad_bin_w
    $error("bcd_to_binary_seq: BIN_W too small for N_DIGITS");
  end

  state_t            state_q, state_d;
  logic [SR_W-1:0]   sreg_q, sreg_d;
  logic [SR_W-1:0]   shifted;
  logic [SR_W-1:0]   corrected;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic              bcd_err_q, bcd_err_d;
  logic              err_in;

  // Shift first, then correct every BCD field in parallel (no digit ripple).
  assign shifted = sreg_q >> 1;
  assign corrected[BIN_W-1:0] = shifted[BIN_W-1:0];

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
    bcd_resta3 u_resta3 (
      .digit_i (shifted  [BIN_W + gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (corrected[BIN_W + gi*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Flag any input digit above 9.
  always_comb begin
    err_in = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT) begin
        err_in = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: exact compare on the last count keeps the exit precise.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values: load on accept, shift/correct, capture on last shift.
  always_comb begin
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    bin_d     = bin_q;
    bcd_err_d = bcd_err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sreg_d = {bcd_in, {BIN_W{1'b0}}};
          err_d  = err_in;
          cnt_d  = '0;
        end
      end
      SHIFT: begin
        sreg_d = corrected;
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          bin_d     = err_q ? '0 : corrected[BIN_W-1:0];
          bcd_err_d = err_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sreg_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      bin_q     <= '0;
      bcd_err_q <= 1'b0;
    end else begin
      sreg_q    <= sreg_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      bin_q     <= bin_d;
      bcd_err_q <= bcd_err_d;
    end
  end

  assign bin_out = bin_q;
  assign bcd_err = bcd_err_q;

endmodule
`default_nettype wire
